// File: rtl/pb1_pio_pkg.sv
// pb1_pio_pkg: shared constants and edge-event helper for the pb1 button PIO.
package pb1_pio_pkg;

    // Avalon word addresses of the register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Captured-edge selection encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit event vector from the previous and current debounced levels
    function automatic logic [31:0] edge_ev(input int edge_type,
                                            input logic [31:0] prev,
                                            input logic [31:0] cur);
        logic [31:0] ev;
        case (edge_type)
            EDGE_RISE: ev = ~prev & cur;
            EDGE_FALL: ev = prev & ~cur;
            default:   ev = prev ^ cur;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/pb1_debounce_bit.sv
// pb1_debounce_bit: single-bit hold-time debouncer. The output follows the
// synchronised input only after it has differed for DB_CYCLES consecutive
// cycles; any return to the current level restarts the count.
module pb1_debounce_bit #(
    parameter int DB_CYCLES  = 50000,
    parameter int IDLE_LEVEL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic stable
);
    localparam int CW = $clog2(DB_CYCLES);

    logic [CW-1:0] cnt;

    // Count cycles of disagreement; commit the new level on the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= (IDLE_LEVEL != 0);
            cnt    <= '0;
        end else if (sync_in == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            stable <= sync_in;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pb1_button_pio.sv
// pb1_button_pio: Avalon-MM input PIO for buttons/switches with 2-flop
// synchroniser, optional debounce (macro PB1_PIO_DEBOUNCE_EN), edge capture
// with write-1-to-clear, interrupt mask and a registered level IRQ.
// Read latency is one cycle; readdata tracks address every cycle.
module pb1_button_pio
    import pb1_pio_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int DB_CYCLES  = 50000,
    parameter int EDGE_TYPE  = 1,
    parameter int IDLE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    localparam logic [WIDTH-1:0] IDLE = (IDLE_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync1, sync2, stable, stable_q;
    logic [WIDTH-1:0] edge_cap, mask, ev, clr;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef PB1_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pb1_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .IDLE_LEVEL(IDLE_LEVEL)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .sync_in(sync2[i]),
            .stable (stable[i])
        );
    end
`else
    logic unused_cfg;
    assign unused_cfg = (DB_CYCLES < 2);

    // Without debounce the stable stage is one more register delay
    always_ff @(posedge clk) begin
        if (reset) stable <= IDLE;
        else       stable <= sync2;
    end
`endif

    // Previous debounced level, for edge detection
    always_ff @(posedge clk) begin
        if (reset) stable_q <= IDLE;
        else       stable_q <= stable;
    end

    assign ev  = WIDTH'(edge_ev(EDGE_TYPE, 32'(stable_q), 32'(stable)));
    assign clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Edge capture: a new event wins over a simultaneous clear of the same bit
    always_ff @(posedge clk) begin
        if (reset) edge_cap <= '0;
        else       edge_cap <= (edge_cap & ~clr) | ev;
    end

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset)                              mask <= '0;
        else if (write && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
    end

    // Zero-extended read mux
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = stable;
            ADDR_RSVD: rd_next = '0;
            ADDR_MASK: rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_cap;
            default:   rd_next = '0;
        endcase
    end

    // Registered read data and level IRQ
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_next;
            irq      <= |(edge_cap & mask);
        end
    end

endmodule
